// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker. A held lock pins the choice to its owner
// while the owner keeps requesting; otherwise a tie goes to the port that
// was not granted last.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock_valid,
  input  logic       lock_owner,
  output logic       sel
);

  // Winner selection; a lone requester always wins.
  always_comb begin
    sel = P0;
    if (lock_valid && req[lock_owner]) sel = lock_owner;
    else if (&req)                     sel = ~last;
    else if (req[1])                   sel = P1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU (port 0) and the
// debug/DMA loader (port 1). IDLE picks a winner and registers its access,
// ISSUE drives the memory for one cycle. Define DMEM_ARB_LOCK_EN to let a
// requester keep ownership across accesses (atomic read-modify-write).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state, state_nx;
  logic [1:0]        req;
  logic              win;
  logic              sel_q, sel_we, last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              lock_valid, lock_owner;

  assign req = {req1, req0};

  rr_arb2 u_rr (
    .req        (req),
    .last       (last_grant),
    .lock_valid (lock_valid),
    .lock_owner (lock_owner),
    .sel        (win)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and issue-cycle outputs; mem_we stays purely combinational
  // so an async reset drops it at once.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    mem_we   = 1'b0;
    case (state)
      IDLE:  if (|req) state_nx = ISSUE;
      ISSUE: begin
        state_nx = IDLE;
        busy     = 1'b1;
        gnt0     = (sel_q == P0);
        gnt1     = (sel_q == P1);
        mem_we   = sel_we;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Latch the winner's access while arbitrating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= P0;
      sel_we  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && |req) begin
      sel_q   <= win;
      sel_we  <= win ? we1 : we0;
      addr_q  <= win ? addr1 : addr0;
      wdata_q <= win ? wdata1 : wdata0;
    end
  end

  // Round-robin history; reset favours port 0 on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               last_grant <= P1;
    else if (state == ISSUE)  last_grant <= sel_q;
  end

  // Capture read data at the end of ISSUE and pulse the owner's rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid0 <= (state == ISSUE) && !sel_we && (sel_q == P0);
      rvalid1 <= (state == ISSUE) && !sel_we && (sel_q == P1);
      if (state == ISSUE && !sel_we) rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  // Ownership lock: taken by a granted access with lock set, released when
  // the owner is granted without lock or stops requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_valid <= 1'b0;
      lock_owner <= P0;
    end else if (state == ISSUE) begin
      if (sel_q ? lock1 : lock0) begin
        lock_valid <= 1'b1;
        lock_owner <= sel_q;
      end else if (lock_valid && lock_owner == sel_q) begin
        lock_valid <= 1'b0;
      end
    end else if (lock_valid && !req[lock_owner]) begin
      lock_valid <= 1'b0;
    end
  end
`else
  logic unused_lock;
  assign lock_valid  = 1'b0;
  assign lock_owner  = P0;
  assign unused_lock = lock0 ^ lock1;
`endif

endmodule
